// File: rtl/cpu_banked_fsr_datapath.sv
// cpu_banked_fsr_datapath
//   FSR, bank-select register and a banked general-purpose file. The lowest
//   SHARED_N offsets of every bank fold onto bank 0, which gives a common area.
//   A direct offset of 0 (INDF) turns into an indirect access through the FSR.
//   After reset the whole file is cleared one word per cycle. During that fill
//   busy is high and all CPU requests are ignored.
//
// Optional feature macro: FSR_AUTOINC_EN
//   When defined, inc_fsr post-increments the FSR after an indirect access.
//   When undefined, inc_fsr is ignored.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instruction_reg_output   direct file offset (OFS_W bits)
//   alu_output               write data for the file, FSR and bank register
//   load_ram / load_fsr / load_bank / inc_fsr   CPU write strobes
//   ram_out                  combinational read of the effective address
//   fsr_reg_out, bank_reg_out  current FSR and bank select
//   eff_addr                 resolved file address
//   busy                     high during reset and the post-reset fill
module cpu_banked_fsr_datapath #(
  parameter int DATA_W   = 8,
  parameter int OFS_W    = 5,
  parameter int BANK_W   = 2,
  parameter int SHARED_N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OFS_W-1:0]        instruction_reg_output,
  input  logic [DATA_W-1:0]       alu_output,
  input  logic                    load_ram,
  input  logic                    load_fsr,
  input  logic                    load_bank,
  input  logic                    inc_fsr,
  output logic [DATA_W-1:0]       ram_out,
  output logic [DATA_W-1:0]       fsr_reg_out,
  output logic [BANK_W-1:0]       bank_reg_out,
  output logic [BANK_W+OFS_W-1:0] eff_addr,
  output logic                    busy
);

  localparam int AW    = BANK_W + OFS_W;
  localparam int DEPTH = 2 ** AW;
  // One extra bit so SHARED_N == 2**OFS_W is still representable.
  localparam logic [OFS_W:0] SHARED_LIM = (OFS_W + 1)'(SHARED_N);

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] fsr;
  logic [BANK_W-1:0] bank;
  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              indirect;
  logic              self_ref;
  logic              do_inc;
  logic [AW-1:0]     raw;
  logic [OFS_W-1:0]  ofs;

  assign run          = (state == ST_RUN);
  assign fsr_reg_out  = fsr;
  assign bank_reg_out = bank;

  // Address resolution. Offset 0 selects the FSR as a pointer. Low offsets of
  // any bank fold onto bank 0. An indirect pointer whose own offset is 0 would
  // point back at INDF, so it is flagged as a self-reference.
  always_comb begin
    indirect = (instruction_reg_output == '0);
    raw      = indirect ? fsr[AW-1:0] : {bank, instruction_reg_output};
    ofs      = raw[OFS_W-1:0];
    eff_addr = ({1'b0, ofs} < SHARED_LIM) ? {{BANK_W{1'b0}}, ofs} : raw;
    self_ref = indirect && (ofs == '0);
  end

  // Reads are forced to zero while filling and for the INDF self-reference.
  assign ram_out = (!run || self_ref) ? '0 : mem[eff_addr];

`ifdef FSR_AUTOINC_EN
  assign do_inc = inc_fsr && indirect;
`else
  logic unused_inc_fsr;
  assign unused_inc_fsr = inc_fsr;
  assign do_inc         = 1'b0;
`endif

  // Control state. FILL walks cnt over the whole file, and busy falls on the
  // edge that clears the last word. In RUN, load_fsr has priority over the
  // post-increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      fsr   <= '0;
      bank  <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (!run) begin
      cnt <= cnt + AW'(1);
      if (&cnt) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end
    end else begin
      if (load_fsr)
        fsr <= alu_output;
      else if (do_inc)
        fsr <= fsr + DATA_W'(1);
      if (load_bank)
        bank <= alu_output[BANK_W-1:0];
    end
  end

  // File storage. It has no reset of its own: the fill clears it, and in RUN
  // the ALU writes to the address resolved from the pre-edge FSR and bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)
        mem[cnt] <= '0;
      else if (load_ram && !self_ref)
        mem[eff_addr] <= alu_output;
    end
  end

endmodule

// File: tb/tb_cpu_banked_fsr_datapath.sv
// tb_cpu_banked_fsr_datapath
//   Directed bench. Stimulus tasks push the expected response into a
//   scoreboard queue. A monitor on the falling edge pops the entries and
//   compares them with the DUT outputs.
module tb_cpu_banked_fsr_datapath;

  logic       clk;
  logic       rst;
  logic [4:0] instruction_reg_output;
  logic [7:0] alu_output;
  logic       load_ram, load_fsr, load_bank, inc_fsr;
  logic [7:0] ram_out, fsr_reg_out;
  logic [1:0] bank_reg_out;
  logic [6:0] eff_addr;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef FSR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // mask bits: 0 ram_out, 1 fsr, 2 bank, 3 eff_addr, 4 busy
  typedef struct {
    string      name;
    bit [4:0]   mask;
    logic [7:0] ram;
    logic [7:0] fsr;
    logic [1:0] bank;
    logic [6:0] addr;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  cpu_banked_fsr_datapath dut (
    .clk                    (clk),
    .rst                    (rst),
    .instruction_reg_output (instruction_reg_output),
    .alu_output             (alu_output),
    .load_ram               (load_ram),
    .load_fsr               (load_fsr),
    .load_bank              (load_bank),
    .inc_fsr                (inc_fsr),
    .ram_out                (ram_out),
    .fsr_reg_out            (fsr_reg_out),
    .bank_reg_out           (bank_reg_out),
    .eff_addr               (eff_addr),
    .busy                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask[0]) begin
        tests_run++;
        if (ram_out !== e.ram) begin
          tests_failed++;
          $display("[TB] FAIL %s ram_out got %h want %h", e.name, ram_out, e.ram);
        end
      end
      if (e.mask[1]) begin
        tests_run++;
        if (fsr_reg_out !== e.fsr) begin
          tests_failed++;
          $display("[TB] FAIL %s fsr got %h want %h", e.name, fsr_reg_out, e.fsr);
        end
      end
      if (e.mask[2]) begin
        tests_run++;
        if (bank_reg_out !== e.bank) begin
          tests_failed++;
          $display("[TB] FAIL %s bank got %h want %h", e.name, bank_reg_out, e.bank);
        end
      end
      if (e.mask[3]) begin
        tests_run++;
        if (eff_addr !== e.addr) begin
          tests_failed++;
          $display("[TB] FAIL %s eff_addr got %h want %h", e.name, eff_addr, e.addr);
        end
      end
      if (e.mask[4]) begin
        tests_run++;
        if (busy !== e.busy) begin
          tests_failed++;
          $display("[TB] FAIL %s busy got %b want %b", e.name, busy, e.busy);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge. They commit on the next edge.
  task automatic applyStimulus(input logic [4:0] ir, input logic [7:0] alu,
                               input bit lr, input bit lf, input bit lb, input bit inc);
    @(posedge clk);
    #1;
    rst                    = 1'b0;
    instruction_reg_output = ir;
    alu_output             = alu;
    load_ram               = lr;
    load_fsr               = lf;
    load_bank              = lb;
    inc_fsr                = inc;
  endtask

  // Queue an expectation for the current cycle.
  task automatic checkOutput(input string name, input bit [4:0] mask,
                             input logic [7:0] ram, input logic [7:0] fsr,
                             input logic [1:0] bank, input logic [6:0] addr,
                             input logic bsy);
    exp_t e;
    e.name = name; e.mask = mask; e.ram = ram; e.fsr = fsr;
    e.bank = bank; e.addr = addr; e.busy = bsy;
    sb.push_back(e);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    instruction_reg_output = '0; alu_output = '0;
    load_ram = 0; load_fsr = 0; load_bank = 0; inc_fsr = 0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Release reset and check n cycles of the fill. With junk set, all strobes
  // stay asserted until the final fill edge.
  task automatic runFill(input bit junk, input int n);
    for (int k = 0; k <= n; k++) begin
      if (junk && k < 128) applyStimulus(5'h12, 8'h5A, 1, 1, 1, 1);
      else                 applyStimulus(5'h00, 8'h00, 0, 0, 0, 0);
      checkOutput($sformatf("fill%0d", k), 5'b10111, 8'h00, 8'h00, 2'd0, 7'h0,
                  (k < 128));
    end
  endtask

  task automatic setBank(input logic [1:0] b);
    applyStimulus(5'h01, {6'b0, b}, 0, 0, 1, 0);
  endtask

  task automatic setFsr(input logic [7:0] v);
    applyStimulus(5'h01, v, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    instruction_reg_output = '0; alu_output = '0;
    load_ram = 0; load_fsr = 0; load_bank = 0; inc_fsr = 0;

    // Power-up reset and fill
    doReset(2);
    runFill(0, 128);

    // Every reachable address reads zero
    for (int b = 0; b < 4; b++) begin
      setBank(2'(b));
      for (int o = 1; o < 32; o++) begin
        logic [6:0] a;
        a = (o < 8) ? 7'(o) : 7'(b * 32 + o);
        applyStimulus(5'(o), 8'h00, 0, 0, 0, 0);
        checkOutput($sformatf("sweep b%0d o%0d", b, o), 5'b01101, 8'h00, 8'h00,
                    2'(b), a, 1'b0);
      end
    end

    // Banked direct access
    setBank(2'd1);
    applyStimulus(5'h12, 8'h3C, 1, 0, 0, 0);
    checkOutput("bank1 wr", 5'b01100, 8'h00, 8'h00, 2'd1, 7'h32, 1'b0);
    applyStimulus(5'h12, 8'h00, 0, 0, 0, 0);
    checkOutput("bank1 rd", 5'b01001, 8'h3C, 8'h00, 2'd1, 7'h32, 1'b0);
    setBank(2'd2);
    applyStimulus(5'h12, 8'h00, 0, 0, 0, 0);
    checkOutput("bank2 rd", 5'b01001, 8'h00, 8'h00, 2'd2, 7'h52, 1'b0);

    // Shared area
    setBank(2'd3);
    applyStimulus(5'h05, 8'h77, 1, 0, 0, 0);
    checkOutput("shared wr", 5'b01000, 8'h00, 8'h00, 2'd3, 7'h05, 1'b0);
    setBank(2'd0);
    applyStimulus(5'h05, 8'h00, 0, 0, 0, 0);
    checkOutput("shared rd", 5'b01001, 8'h77, 8'h00, 2'd0, 7'h05, 1'b0);

    // Indirect: raw 0x45 has offset 5, which folds onto the shared word 0x05
    setFsr(8'hC5);
    applyStimulus(5'h00, 8'hA5, 1, 0, 0, 0);
    checkOutput("ind wr", 5'b01010, 8'h00, 8'hC5, 2'd0, 7'h05, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, 0, 0);
    checkOutput("ind rd", 5'b00001, 8'hA5, 8'h00, 2'd0, 7'h00, 1'b0);
    setFsr(8'h80);
    applyStimulus(5'h00, 8'h99, 1, 0, 0, 0);
    checkOutput("indf self", 5'b01011, 8'h00, 8'h80, 2'd0, 7'h00, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, 0, 0);
    checkOutput("indf self rd", 5'b00001, 8'h00, 8'h00, 2'd0, 7'h00, 1'b0);
    applyStimulus(5'h05, 8'h00, 0, 0, 0, 0);
    checkOutput("indf drop", 5'b00001, 8'hA5, 8'h00, 2'd0, 7'h00, 1'b0);
    setFsr(8'h03);
    applyStimulus(5'h00, 8'h33, 1, 0, 0, 0);
    checkOutput("ind shared wr", 5'b01000, 8'h00, 8'h00, 2'd0, 7'h03, 1'b0);
    setBank(2'd1);
    applyStimulus(5'h03, 8'h00, 0, 0, 0, 0);
    checkOutput("ind shared rd", 5'b01001, 8'h33, 8'h00, 2'd0, 7'h03, 1'b0);

    // Post-increment
    setFsr(8'hFE);
    applyStimulus(5'h00, 8'h01, 1, 0, 0, 1);
    checkOutput("inc0", 5'b01010, 8'h00, 8'hFE, 2'd0, 7'h7E, 1'b0);
    applyStimulus(5'h00, 8'h02, 1, 0, 0, 1);
    checkOutput("inc1", 5'b01010, 8'h00, AUTOINC ? 8'hFF : 8'hFE, 2'd0,
                AUTOINC ? 7'h7F : 7'h7E, 1'b0);
    applyStimulus(5'h00, 8'h03, 1, 0, 0, 1);
    checkOutput("inc2", 5'b01010, 8'h00, AUTOINC ? 8'h00 : 8'hFE, 2'd0,
                AUTOINC ? 7'h00 : 7'h7E, 1'b0);
    applyStimulus(5'h01, 8'h00, 0, 0, 0, 0);
    checkOutput("inc3", 5'b00010, 8'h00, AUTOINC ? 8'h01 : 8'hFE, 2'd0, 7'h0, 1'b0);
    setBank(2'd3);
    applyStimulus(5'h1E, 8'h00, 0, 0, 0, 0);
    checkOutput("inc mem7E", 5'b01001, AUTOINC ? 8'h01 : 8'h03, 8'h00, 2'd0,
                7'h7E, 1'b0);
    applyStimulus(5'h1F, 8'h00, 0, 0, 0, 0);
    checkOutput("inc mem7F", 5'b01001, AUTOINC ? 8'h02 : 8'h00, 8'h00, 2'd0,
                7'h7F, 1'b0);
    applyStimulus(5'h00, 8'h40, 0, 1, 0, 1);
    applyStimulus(5'h05, 8'h00, 0, 0, 0, 1);
    checkOutput("load beats inc", 5'b00010, 8'h00, 8'h40, 2'd0, 7'h0, 1'b0);
    applyStimulus(5'h05, 8'h00, 0, 0, 0, 0);
    checkOutput("direct no inc", 5'b00010, 8'h00, 8'h40, 2'd0, 7'h0, 1'b0);

    // Write and load_fsr together use the old FSR target
    setFsr(8'h69);
    applyStimulus(5'h00, 8'h2A, 1, 1, 0, 0);
    checkOutput("wr+lf addr", 5'b01000, 8'h00, 8'h00, 2'd0, 7'h69, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, 0, 0);
    checkOutput("wr+lf new", 5'b01011, 8'h00, 8'h2A, 2'd0, 7'h2A, 1'b0);
    applyStimulus(5'h09, 8'h00, 0, 0, 0, 0);
    checkOutput("wr+lf old", 5'b01001, 8'h2A, 8'h00, 2'd0, 7'h69, 1'b0);

    // Mid-fill reset restarts the fill; strobes are ignored while busy
    doReset(2);
    runFill(0, 50);
    doReset(1);
    runFill(1, 128);
    setBank(2'd1);
    applyStimulus(5'h12, 8'h00, 0, 0, 0, 0);
    checkOutput("refill 32", 5'b00101, 8'h00, 8'h00, 2'd1, 7'h0, 1'b0);
    setBank(2'd3);
    applyStimulus(5'h09, 8'h00, 0, 0, 0, 0);
    checkOutput("refill 69", 5'b00001, 8'h00, 8'h00, 2'd0, 7'h0, 1'b0);
    applyStimulus(5'h1E, 8'h00, 0, 0, 0, 0);
    checkOutput("refill 7E", 5'b00001, 8'h00, 8'h00, 2'd0, 7'h0, 1'b0);
    applyStimulus(5'h05, 8'h00, 0, 0, 0, 0);
    checkOutput("refill 05", 5'b00001, 8'h00, 8'h00, 2'd0, 7'h0, 1'b0);
    applyStimulus(5'h03, 8'h00, 0, 0, 0, 0);
    checkOutput("refill 03", 5'b00001, 8'h00, 8'h00, 2'd0, 7'h0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard drain got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
